// File: rtl/inst_fetch_resp_pkg.sv
// inst_fetch_resp_pkg: shared front-end fetch types and constants
package inst_fetch_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int CNT_W = 3;
endpackage

// File: rtl/inst_fetch_resp_ram.sv
// inst_ram: instruction store, synchronous write, asynchronous read
module inst_ram #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [31:0]           rd_data
);
  logic [31:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp: fixed-latency instruction fetch responder with valid/ready handshake
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE       = RESET_PC,
  parameter logic [31:0] NOP        = NOP_INST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  req_valid,
  input  logic [31:0]           req_pc,
  output logic                  req_ready,
  output logic                  stall,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_pc,
  output logic [31:0]           resp_inst,
  output logic                  resp_fault,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [31:0]           wr_data
);
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pc_q, off, rd_data;
  logic             accept, capture, fault;
  assign req_ready  = en & ~flush & ((state == IDLE) | ((state == DONE) & resp_ready));
  assign stall      = req_valid & ~req_ready;
  assign accept     = req_valid & req_ready;
  assign capture    = (state == WAIT) && (cnt == '0);
  assign resp_valid = state == DONE;
  // 33-bit compare so the bound is exact even when the store fills the address space
  assign off   = pc_q - BASE;
  assign fault = (|pc_q[1:0]) | (pc_q < BASE) | ({1'b0, off} >= (33'd4 << DEPTH_LOG2));
  inst_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (off[DEPTH_LOG2+1:2]),
    .rd_data (rd_data)
  );
  always_comb begin
    state_nx = flush ? IDLE :
               accept ? WAIT :
               capture ? DONE :
               ((state == DONE) && resp_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pc_q       <= '0;
      resp_pc    <= '0;
      resp_inst  <= NOP;
      resp_fault <= 1'b0;
    end else if (en) begin
      state <= state_nx;
      cnt   <= flush ? '0 :
               accept ? CNT_W'(LATENCY - 1) :
               ((state == WAIT) && (cnt != '0)) ? cnt - CNT_W'(1) : cnt;
      if (accept) pc_q <= req_pc;
      if (capture && !flush) begin
        resp_pc    <= pc_q;
        resp_inst  <= fault ? NOP : rd_data;
        resp_fault <= fault;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_resp.sv
// tb_inst_fetch_resp: scoreboard bench with a spec-level fetch model
module tb_inst_fetch_resp;
  localparam int          L  = 2;
  localparam int          DL = 12;
  localparam logic [31:0] B  = 32'h0040_0000;
  localparam logic [31:0] N  = 32'h0000_0013;
  logic clk = 0, rst = 1, en = 1, flush = 0, req_valid = 0, resp_ready = 1, wr_en = 0;
  logic [31:0] req_pc = '0, wr_data = '0;
  logic [DL-1:0] wr_addr = '0;
  logic req_ready, stall, resp_valid, resp_fault;
  logic [31:0] resp_pc, resp_inst;
  inst_fetch_resp #(.DEPTH_LOG2(DL), .LATENCY(L), .BASE(B), .NOP(N)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .req_valid(req_valid), .req_pc(req_pc),
    .req_ready(req_ready), .stall(stall), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_pc(resp_pc), .resp_inst(resp_inst), .resp_fault(resp_fault),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] pc; logic [31:0] inst; logic fault; int due;} exp_t;
  exp_t q[$];
  exp_t cur;
  logic [31:0] shadow [2**DL];
  int checks = 0, failures = 0, ecyc = 0, cyc = 0;
  bit presented = 0, have = 0, rmode = 0;
  // ecyc counts enabled edges: latency is measured in these
  always @(posedge clk) begin
    cyc++;
    if (en && !rst) ecyc++;
  end
  function automatic exp_t model(input logic [31:0] pc, input int due);
    exp_t m;
    longint off;
    off = longint'({32'b0, pc}) - longint'({32'b0, B});
    m.pc = pc;
    m.due = due;
    m.fault = (pc[1:0] != 2'b0) || (off < 0) || (off >= (longint'(4) << DL));
    m.inst = m.fault ? N : shadow[off[DL+1:2]];
    return m;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (resp_valid) begin
      if (!presented) begin
        presented = 1;
        have = q.size() > 0;
        if (!have) begin
          checks++; failures++;
          $display("FAIL unexpected_resp actual pc=%h required=no response", resp_pc);
        end else begin
          cur = q[0];
          chk("resp_latency", 64'(ecyc), 64'(cur.due));
        end
      end
      if (have) begin
        chk("resp_pc", resp_pc, cur.pc);
        chk("resp_inst", resp_inst, cur.inst);
        chk("resp_fault", resp_fault, cur.fault);
      end
      if (resp_ready && en && !flush) begin
        presented = 0;
        if (have) void'(q.pop_front());
      end
    end else if (q.size() > 0 && ecyc > q[0].due) begin
      checks++; failures++;
      $display("FAIL missing_resp actual=none required pc=%h", q[0].pc);
      void'(q.pop_front());
    end
  end
  initial forever begin
    @(posedge clk); #1;
    if (rmode) begin
      resp_ready = $urandom_range(0, 3) != 0;
      en = $urandom_range(0, 7) != 0;
    end
  end
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic req(input logic [31:0] pc);
    req_valid = 1;
    req_pc = pc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        chk("stall_on_accept", stall, 0);
        q.push_back(model(pc, ecyc + 1 + L));
        tick();
        req_valid = 0;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL req_timeout actual=not accepted required=accept pc=%h", pc);
    req_valid = 0;
  endtask
  task automatic write_word(input int a, input logic [31:0] d);
    wr_en = 1; wr_addr = DL'(a); wr_data = d;
    tick();
    shadow[a] = d;
    wr_en = 0;
  endtask
  task automatic flush_cycle();
    flush = 1;
    tick();
    flush = 0;
    q.delete();
    presented = 0;
    @(negedge clk);
    chk("flush_valid_drop", resp_valid, 0);
    tick();
  endtask
  initial begin
    int c0;
    logic [31:0] pc;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_pc", resp_pc, 0);
    chk("rst_resp_inst", resp_inst, N);
    chk("rst_resp_fault", resp_fault, 0);
    rst = 0;
    tick();
    write_word(0, 32'h0010_0093);
    for (int i = 1; i < 16; i++) write_word(i, $urandom);
    write_word(4095, $urandom);
    // basic fetch, then a second request stalls while the first is in WAIT
    req(B);
    req_valid = 1; req_pc = B + 4;
    @(negedge clk);
    chk("stall_in_wait", stall, 1);
    chk("req_ready_in_wait", req_ready, 0);
    req(B + 4);
    req(B + 2);
    req(32'h003F_FFFC);
    req(B + 4 * 4095);
    req(B + 4 * 4096);
    req(32'hFFFF_FFFC);
    repeat (L + 3) tick();
    // hold in DONE, then release with a same-edge new request
    resp_ready = 0;
    req(B + 8);
    repeat (L) tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_req_ready", req_ready, 0);
    end
    tick();
    resp_ready = 1;
    req(B + 12);
    repeat (L + 3) tick();
    // flush in WAIT and in DONE
    req(B + 16);
    flush_cycle();
    repeat (5) tick();
    resp_ready = 0;
    req(B + 20);
    repeat (L) tick();
    flush_cycle();
    resp_ready = 1;
    repeat (5) tick();
    // flush with en low is ignored, in DONE and in WAIT
    resp_ready = 0;
    req(B + 24);
    repeat (L) tick();
    en = 0; flush = 1;
    tick();
    en = 1; flush = 0;
    @(negedge clk);
    chk("flush_en0_done_kept", resp_valid, 1);
    tick();
    resp_ready = 1;
    repeat (3) tick();
    req(B + 28);
    en = 0; flush = 1;
    tick();
    en = 1; flush = 0;
    repeat (L + 4) tick();
    // en low for three cycles mid-WAIT
    req(B + 32);
    c0 = cyc;
    en = 0;
    repeat (3) tick();
    en = 1;
    for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
    chk("en_hold_delay", 64'(cyc - c0), 64'(L + 3));
    repeat (3) tick();
    // async reset mid-WAIT
    req(B + 36);
    #1 rst = 1;
    #1;
    chk("rst_mid_valid", resp_valid, 0);
    chk("rst_mid_pc", resp_pc, 0);
    chk("rst_mid_inst", resp_inst, N);
    chk("rst_mid_fault", resp_fault, 0);
    q.delete();
    presented = 0;
    tick();
    rst = 0;
    repeat (6) tick();
    // store write on the capture edge returns old contents
    write_word(5, 32'hAAAA_0001);
    req(B + 20);
    tick();
    wr_en = 1; wr_addr = DL'(5); wr_data = 32'h5555_0002;
    tick();
    wr_en = 0;
    shadow[5] = 32'h5555_0002;
    repeat (2) tick();
    req(B + 20);
    repeat (L + 3) tick();
    // randomized traffic
    rmode = 1;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0: pc = B + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
        1: pc = B - 32'($urandom_range(1, 64));
        2: pc = B + 32'h4000 + 32'($urandom_range(0, 64) * 4);
        default: pc = B + 32'($urandom_range(0, 15) * 4);
      endcase
      if (q.size() == 0 && $urandom_range(0, 4) == 0) write_word($urandom_range(0, 15), $urandom);
      req(pc);
    end
    rmode = 0;
    en = 1;
    resp_ready = 1;
    for (int i = 0; i < 100 && q.size() > 0; i++) tick();
    chk("queue_drained", 64'(q.size()), 0);
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
